// File: rtl/bus_memory_slave_if.sv
// Data-bus handshake between the core's load/store master and the memory slave.
// The master holds a request while bus_wait_req is high; bus_valid strobes read data.
interface bus_memory_slave_if;
  logic [31:0] bus_address;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_read_data;
  logic        bus_wait_req;
  logic        bus_valid;

  modport master (
    output bus_address, bus_read_enable, bus_write_enable, bus_write_data, bus_byte_enable,
    input  bus_read_data, bus_wait_req, bus_valid
  );

  modport slave (
    input  bus_address, bus_read_enable, bus_write_enable, bus_write_data, bus_byte_enable,
    output bus_read_data, bus_wait_req, bus_valid
  );
endinterface

// File: rtl/bus_memory_slave.sv
// Word-addressed RAM slave with programmable read latency and a write-once
// test-status register that reports done/pass to the simulation harness.
module bus_memory_slave #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] STATUS_ADDR = 32'hffff_fff0
) (
  input  logic               clock,
  input  logic               reset,
  bus_memory_slave_if.slave  bus,
  output logic               test_done,
  output logic               test_pass,
  output logic               bus_error
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] resp;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          is_status;
  logic          accept;
  logic          is_write;
  logic          mem_we;

  always_comb begin
    offset    = bus.bus_address - BASE_ADDR;
    idx       = offset[AW+1:2];
    in_range  = offset[31:2] < 30'(DEPTH_WORDS);
    is_status = bus.bus_address[31:2] == STATUS_ADDR[31:2];
    accept    = (bus.bus_read_enable || bus.bus_write_enable) && !bus.bus_wait_req;
    // Both enables together resolve to a write.
    is_write  = bus.bus_write_enable;
    mem_we    = accept && is_write && in_range && !is_status;
  end

  assign bus.bus_wait_req  = (state == WAIT) && (cnt != 4'd0);
  assign bus.bus_valid     = (state == WAIT) && (cnt == 4'd0);
  assign bus.bus_read_data = resp;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      resp      <= 32'd0;
      test_done <= 1'b0;
      test_pass <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else if (state == WAIT) begin
        state <= IDLE;
      end

      // A read accepted in the valid cycle overrides the return to IDLE above.
      if (accept) begin
        if (is_write) begin
          if (is_status && !test_done) begin
            test_done <= 1'b1;
            test_pass <= |bus.bus_write_data;
          end
          if (bus.bus_read_enable || (!in_range && !is_status)) begin
            bus_error <= 1'b1;
          end
        end else begin
          if (is_status) begin
            resp <= {31'd0, test_pass};
          end else if (in_range) begin
            resp <= mem[idx];
          end else begin
            resp      <= 32'd0;
            bus_error <= 1'b1;
          end
          cnt   <= 4'(LATENCY - 1);
          state <= WAIT;
        end
      end
    end
  end

  // NOTE: RAM has no reset branch so it maps onto block RAM and keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.bus_byte_enable[i]) begin
          mem[idx][8*i +: 8] <= bus.bus_write_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/bus_memory_slave.md
# bus_memory_slave

Word-addressed RAM slave that sits directly downstream of the core's data bus and answers its wait-request/valid handshake with a programmable read latency. It also decodes one memory-mapped test-status register: the first write there latches a done/pass result for the simulation harness. Used in simulation and FPGA smoke builds as the data-side memory behind `toplevel`.

## Interface
- `DEPTH_WORDS`, 16384: RAM size in 32-bit words (64 KiB); power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `LATENCY`, 2: cycles from read acceptance to `bus_valid`; legal range 1..15.
- `STATUS_ADDR`, 32'hffff_fff0: byte address of the test-status register.

- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `bus_address` in 32: byte address; bits [1:0] ignored.
- `bus_read_enable` in 1: read request.
- `bus_write_enable` in 1: write request.
- `bus_write_data` in 32: write data, lane i = bits [8i+7:8i].
- `bus_byte_enable` in 4: per-lane write strobe.
- `bus_read_data` out 32: read data, meaningful only while `bus_valid`.
- `bus_wait_req` out 1: high = request this cycle not accepted, master must hold.
- `bus_valid` out 1: one-cycle read-data strobe.
- `test_done` out 1: sticky, status register written.
- `test_pass` out 1: sticky, status value was non-zero.
- `bus_error` out 1: sticky, illegal access seen.

## Operation
- States: IDLE, WAIT. Counter `cnt` is 4 bits wide.
- Acceptance: a request is accepted on an edge where (`bus_read_enable` or `bus_write_enable`) and `bus_wait_req`=0.
- Writes: RAM lanes with `bus_byte_enable[i]`=1 are updated at the accepting edge. No response; `bus_valid` is never raised for a write. State after the edge is IDLE.
- Reads: the full word at index (`bus_address`-`BASE_ADDR`)>>2 is captured into the response register at the accepting edge. Byte enables are ignored for reads. At the same edge `cnt`<=`LATENCY`-1 and the state becomes WAIT.
- In WAIT: `cnt` decrements each cycle while non-zero.
  - `bus_wait_req` = WAIT && `cnt`!=0.
  - `bus_valid` = WAIT && `cnt`==0.
  - In the valid cycle a new request may be accepted. A read reloads `cnt`; a write, or no request, returns the state to IDLE.
- Both enables high: treated as a write. `bus_error` is set.
- Out-of-range address: outside [`BASE_ADDR`, `BASE_ADDR`+4*`DEPTH_WORDS`) and not `STATUS_ADDR`.
  - Writes are dropped.
  - Reads return 32'h0 with normal timing.
  - `bus_error` is set in both cases.
- Status register, write to `STATUS_ADDR`:
  - If `test_done`=0: `test_done`<=1 and `test_pass`<=|`bus_write_data` (byte enables ignored).
  - Later writes are ignored, so the first result wins.
  - A read returns {31'b0, `test_pass`}.
- Reset clears state to IDLE, `cnt`, the response register and all flags. RAM contents are not cleared. Requests present during reset are ignored.

## Timing
- Reset values: `bus_read_data`=0, `bus_valid`=0, `bus_wait_req`=0, `test_done`=0, `test_pass`=0, `bus_error`=0.
- Read latency: read accepted at edge k → `bus_valid` high for cycle k+`LATENCY` (the cycle after edge k+`LATENCY`-1 ... i.e. exactly `LATENCY` cycles after acceptance) → `bus_wait_req` high for the `LATENCY`-1 cycles between.
- `LATENCY`=1: no wait cycles; back-to-back reads deliver one word per cycle.
- Throughput: one read per `LATENCY` cycles; one write per cycle while idle.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
- A write accepted in a read's valid cycle does not alter the response already in flight.
- Reset asserted while in WAIT: the pending response is dropped, and `bus_valid`=0 from the cycle after the reset edge.
- Flags `test_done`, `test_pass` and `bus_error` update one cycle after the accepting edge. They stay set until reset.

## Test plan
- Write 32'hcafe_f00d to 0x100 with `bus_byte_enable`=4'hf, then read 0x100, `LATENCY`=2 → `bus_wait_req` high 1 cycle, then `bus_valid` for 1 cycle with 32'hcafe_f00d.
- Write 32'h1122_3344 to 0x40, then write 32'haabb_ccdd with `bus_byte_enable`=4'b0101, then read → 32'h11bb_33dd.
- `LATENCY`=1, reads to 0x0, 0x4, 0x8 held continuously → three consecutive `bus_valid` cycles, `bus_wait_req` never high.
- Write 32'h1 to 32'hffff_fff0, then write 32'h0 there → `test_done`=1, `test_pass`=1 after both writes.
- Read 0x0004_0000 with `DEPTH_WORDS`=16384 → data 32'h0 after `LATENCY`, `bus_error`=1. Assert both enables in one cycle → `bus_error` stays 1 and the write is performed.
- Read accepted, `reset` pulsed for 1 cycle before valid → no `bus_valid`, all outputs 0. The word written before reset still reads back unchanged.
